pll_reset_sequencer: RTL and testbench

//  Controller on the far side of the PLL rst/locked interface: drives the PLL reset, qualifies its locked flag,

---
 rtl/pll_reset_seq_pkg.sv | 19 +
 rtl/rst_seq_sync.sv | 24 ++
 rtl/pll_reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_seq_pkg.sv
// Shared types and helpers for the PLL reset sequencer.
package pll_reset_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        ERROR
    } seq_state_t;

    localparam int LOST_CNT_W = 8;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Two-flop synchronizer with asynchronous active-low clear to 0.
module rst_seq_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_reg <= 1'b0;
            sync_reg <= 1'b0;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification and staged downstream reset release.
// Build option PLL_RESET_SEQ_RETRY_EN: lock timeout retries the PLL instead of parking in ERROR.
module pll_reset_sequencer
    import pll_reset_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1000,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int NUM_RESETS          = 4,
    parameter int STAGE_DELAY         = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  sw_reset_req,
    output logic                  pll_rst,
    output logic [NUM_RESETS-1:0] rst_n_out,
    output logic                  ready,
    output logic                  timeout,
    output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

    // A pulse of at least two cycles keeps the first transition off the first edge after reset.
    localparam int PLL_RST_LEN = max_of(PLL_RST_CYCLES, 2);
    localparam int RELEASE_LEN = (NUM_RESETS - 1) * STAGE_DELAY + 1;
    localparam int CNT_MAX     = max_of(max_of(PLL_RST_LEN, LOCK_STABLE_CYCLES),
                                        max_of(LOCK_TIMEOUT_CYCLES, RELEASE_LEN));
    localparam int CNT_W       = $clog2(CNT_MAX) + 1;

    seq_state_t            state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [NUM_RESETS-1:0] rst_n_reg, rst_n_next;
    logic [NUM_RESETS-1:0] stage_hit;
    logic                  timeout_reg, timeout_next;
    logic [LOST_CNT_W-1:0] lost_cnt_reg, lost_cnt_next;
    logic                  lk;
    logic                  lock_loss;
    logic                  restart;

    rst_seq_sync u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked),
        .q       (lk)
    );

    // Stage gi is released at the end of RELEASE cycle gi*STAGE_DELAY.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RESETS; gi++) begin : g_stage
            assign stage_hit[gi] = (state_reg == RELEASE) &&
                                   (cnt_reg == CNT_W'(gi * STAGE_DELAY));
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        timeout_next  = timeout_reg;
        lost_cnt_next = lost_cnt_reg;
        restart       = 1'b0;
        lock_loss     = !lk && ((state_reg == RELEASE) || (state_reg == RUN));

        case (state_reg)
            PLL_RST: begin
                if (cnt_reg == CNT_W'(PLL_RST_LEN - 1))
                    state_next = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_next = STABLE;
                end else if (cnt_reg == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    timeout_next = 1'b1;
`ifdef PLL_RESET_SEQ_RETRY_EN
                    state_next   = PLL_RST;
`else
                    state_next   = ERROR;
`endif
                end
            end
            STABLE: begin
                if (!lk)
                    state_next = WAIT_LOCK;
                else if (cnt_reg == CNT_W'(LOCK_STABLE_CYCLES - 1))
                    state_next = RELEASE;
            end
            RELEASE: begin
                if (!lk)
                    state_next = PLL_RST;
                else if (cnt_reg == CNT_W'(RELEASE_LEN))
                    state_next = RUN;
            end
            RUN: begin
                if (!lk)
                    state_next = PLL_RST;
            end
            ERROR: begin
                state_next = ERROR;
            end
            default: begin
                state_next = PLL_RST;
            end
        endcase

        if (lock_loss && (lost_cnt_reg != '1))
            lost_cnt_next = lost_cnt_reg + 1'b1;

        // Software restart overrides everything but still lets a coincident lock loss count.
        if (sw_reset_req) begin
            state_next   = PLL_RST;
            timeout_next = 1'b0;
            restart      = 1'b1;
        end

        if (restart || (state_next != state_reg))
            cnt_next = '0;
        else if (cnt_reg != '1)
            cnt_next = cnt_reg + 1'b1;
        else
            cnt_next = cnt_reg;

        if ((state_next == RELEASE) || (state_next == RUN))
            rst_n_next = rst_n_reg | stage_hit;
        else
            rst_n_next = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= PLL_RST;
            cnt_reg      <= '0;
            rst_n_reg    <= '0;
            timeout_reg  <= 1'b0;
            lost_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            rst_n_reg    <= rst_n_next;
            timeout_reg  <= timeout_next;
            lost_cnt_reg <= lost_cnt_next;
        end
    end

    assign pll_rst       = (state_reg == PLL_RST);
    assign ready         = (state_reg == RUN);
    assign rst_n_out     = rst_n_reg;
    assign timeout       = timeout_reg;
    assign lock_lost_cnt = lost_cnt_reg;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer (PLL_RST=4, STABLE=8, TIMEOUT=50, 4 resets, STAGE_DELAY=2).
module tb_pll_reset_sequencer;

`ifdef PLL_RESET_SEQ_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       sw_reset_req = 1'b0;
    logic       pll_rst;
    logic [3:0] rst_n_out;
    logic       ready;
    logic       timeout;
    logic [7:0] lock_lost_cnt;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (50),
        .NUM_RESETS          (4),
        .STAGE_DELAY         (2)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pll_locked    (pll_locked),
        .sw_reset_req  (sw_reset_req),
        .pll_rst       (pll_rst),
        .rst_n_out     (rst_n_out),
        .ready         (ready),
        .timeout       (timeout),
        .lock_lost_cnt (lock_lost_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc - t0);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", tag, obs, cyc - t0);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset released on a falling edge; rel cycle = number of rising edges since release.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
        t0 = cyc;
    endtask

    task automatic pulse_sw();
        sw_reset_req = 1'b1;
        step(1);
        sw_reset_req = 1'b0;
    endtask

    logic [3:0] exp_pat [4];
    logic [3:0] ev_p [4];
    int         ev_t [4];
    int         ne;
    logic [3:0] prev;
    logic       inv_bad;
    logic       hung;

    initial begin
        exp_pat[0] = 4'b0001;
        exp_pat[1] = 4'b0011;
        exp_pat[2] = 4'b0111;
        exp_pat[3] = 4'b1111;

        // Reset state
        pll_locked = 1'b1;
        step(2);
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        chk("rst_lost_cnt", 32'(lock_lost_cnt), 32'd0);

        // 1: clean bring-up. WAIT_LOCK at 4, STABLE at 5, RELEASE at 13, bit0 at 14, ready at 21.
        reset_n = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 20 && pll_rst; i++) step(1);
        chk("t1_pll_rst_fall", 32'(cyc - t0), 32'd4);
        ne = 0;
        prev = 4'b0000;
        inv_bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ev_p[k] = 4'b0000;
            ev_t[k] = 0;
        end
        for (int i = 0; i < 100 && !ready; i++) begin
            step(1);
            if (rst_n_out != prev && ne < 4) begin
                ev_p[ne] = rst_n_out;
                ev_t[ne] = cyc - t0;
                ne++;
            end
            prev = rst_n_out;
            if ((rst_n_out & (rst_n_out + 4'd1)) != 4'd0) inv_bad = 1'b1;
            if (ready && rst_n_out != 4'hf) inv_bad = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_stage%0d_pattern", k), 32'(ev_p[k]), 32'(exp_pat[k]));
            chk($sformatf("t1_stage%0d_cycle", k), 32'(ev_t[k]), 32'(14 + 2 * k));
        end
        chk("t1_ready_cycle", 32'(cyc - t0), 32'd21);
        chk("t1_ready", 32'(ready), 32'd1);
        chk("t1_invariants", 32'(inv_bad), 32'd0);

        // 2: one-cycle lock glitch after 5 stable cycles; stable count restarts, release at 21.
        do_reset();
        step(8);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        for (int i = 0; i < 100 && rst_n_out == 4'd0; i++) step(1);
        chk("t2_release_cycle", 32'(cyc - t0), 32'd21);
        chk("t2_lost_cnt", 32'(lock_lost_cnt), 32'd0);
        for (int i = 0; i < 100 && !ready; i++) step(1);
        chk("t2_ready", 32'(ready), 32'd1);

        // 3: lock loss in RUN; registered drop after 2-flop sync + 1 edge.
        pll_locked = 1'b0;
        step(2);
        chk("t3_hold_before_drop", 32'(rst_n_out), 32'hf);
        step(1);
        chk("t3_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("t3_ready", 32'(ready), 32'd0);
        chk("t3_pll_rst", 32'(pll_rst), 32'd1);
        chk("t3_lost_cnt", 32'(lock_lost_cnt), 32'd1);
        pll_locked = 1'b1;
        for (int i = 0; i < 100 && !ready; i++) step(1);
        chk("t3_relock_ready", 32'(ready), 32'd1);
        chk("t3_relock_rst_n", 32'(rst_n_out), 32'hf);

        // 5: software restart mid-RELEASE; lost count preserved.
        pulse_sw();
        chk("t5_sw_pll_rst", 32'(pll_rst), 32'd1);
        for (int i = 0; i < 100 && rst_n_out != 4'b0011; i++) step(1);
        chk("t5_mid_release", 32'(rst_n_out), 32'h3);
        pulse_sw();
        chk("t5_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("t5_pll_rst", 32'(pll_rst), 32'd1);
        chk("t5_timeout", 32'(timeout), 32'd0);
        chk("t5_lost_cnt", 32'(lock_lost_cnt), 32'd1);

        // 4: lock stuck low; WAIT_LOCK from 4, timeout registered at edge 54.
        pll_locked = 1'b0;
        do_reset();
        for (int i = 0; i < 20 && pll_rst; i++) step(1);
        chk("t4_pll_rst_fall", 32'(cyc - t0), 32'd4);
        step(49);
        chk("t4_timeout_pre", 32'(timeout), 32'd0);
        step(1);
        chk("t4_timeout", 32'(timeout), 32'd1);
        chk("t4_pll_rst_after_to", 32'(pll_rst), 32'(RETRY));
        step(10);
        chk("t4_timeout_sticky", 32'(timeout), 32'd1);
        chk("t4_pll_rst_later", 32'(pll_rst), 32'd0);
        chk("t4_rst_n_out", 32'(rst_n_out), 32'd0);
        pulse_sw();
        chk("t4_sw_clears_timeout", 32'(timeout), 32'd0);
        chk("t4_sw_pll_rst", 32'(pll_rst), 32'd1);

        // 6: 300 forced lock losses during RELEASE; saturation at 255.
        pll_locked = 1'b1;
        do_reset();
        hung = 1'b0;
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 100 && !rst_n_out[0]; i++) step(1);
            if (!rst_n_out[0]) hung = 1'b1;
            pll_locked = 1'b0;
            for (int i = 0; i < 10 && !pll_rst; i++) step(1);
            if (!pll_rst) hung = 1'b1;
            pll_locked = 1'b1;
            if (n == 99) chk("t6_lost_cnt_100", 32'(lock_lost_cnt), 32'd100);
        end
        chk("t6_no_stall", 32'(hung), 32'd0);
        chk("t6_lost_cnt_sat", 32'(lock_lost_cnt), 32'd255);
        for (int i = 0; i < 100 && !ready; i++) step(1);
        chk("t6_ready", 32'(ready), 32'd1);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_async_rst_n_out", 32'(rst_n_out), 32'd0);
        chk("t6_async_ready", 32'(ready), 32'd0);
        chk("t6_async_pll_rst", 32'(pll_rst), 32'd1);
        chk("t6_async_lost_cnt", 32'(lock_lost_cnt), 32'd0);
        step(1);
        reset_n = 1'b1;
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
